block_lock_sync: RTL

BLOCK_LOCK_SYNC -- requirements
Module: block_lock_sync

---
 rtl/block_lock_sync.sv | 125 ++++++++++++
 1 files changed

// File: rtl/block_lock_sync.sv
// 64b/66b block lock per lane: hunt for SH_CNT_MAX consecutive good sync headers,
// drop lock on SH_INVALID_MAX bad headers per window, and request gearbox slips.
module block_lock_sync #(
  parameter int NUM_LANES        = 1,
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVALID_MAX   = 16,
  parameter int SLIP_WAIT_CYCLES = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [2*NUM_LANES-1:0]   i_header,
  input  logic [NUM_LANES-1:0]     i_header_valid,
  output logic [NUM_LANES-1:0]     o_slip,
  output logic [NUM_LANES-1:0]     o_block_lock,
  output logic                     o_all_locked,
  output logic [16*NUM_LANES-1:0]  o_lock_loss_count
);

  localparam int               CNT_W     = $clog2(SH_CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SH_CNT_MAX);
  localparam logic [CNT_W-1:0] INV_MAX   = CNT_W'(SH_INVALID_MAX);
  localparam logic [7:0]       WAIT_LAST = 8'(SLIP_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_TEST      = 2'd0,
    ST_SLIP      = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } lane_state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lane_state_t      state_reg;
      logic [CNT_W-1:0] sh_cnt_reg;
      logic [CNT_W-1:0] sh_inv_cnt_reg;
      logic [7:0]       wait_cnt_reg;
      logic             lock_reg;
      logic             slip_reg;
      logic [15:0]      loss_cnt_reg;

      logic [1:0]       hdr;
      logic             hdr_vld;
      logic             hdr_ok;
      logic [CNT_W-1:0] sh_cnt_next;
      logic [CNT_W-1:0] sh_inv_cnt_next;

      assign hdr             = i_header[2*gi +: 2];
      assign hdr_vld         = i_header_valid[gi];
      assign hdr_ok          = hdr[1] ^ hdr[0];
      assign sh_cnt_next     = sh_cnt_reg + CNT_W'(1);
      assign sh_inv_cnt_next = hdr_ok ? sh_inv_cnt_reg : sh_inv_cnt_reg + CNT_W'(1);

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          state_reg      <= ST_TEST;
          sh_cnt_reg     <= '0;
          sh_inv_cnt_reg <= '0;
          wait_cnt_reg   <= '0;
          lock_reg       <= 1'b0;
          slip_reg       <= 1'b0;
          loss_cnt_reg   <= '0;
        end else begin
          slip_reg <= 1'b0;
          case (state_reg)
            ST_TEST: begin
              if (hdr_vld) begin
                if (!hdr_ok && !lock_reg) begin
                  state_reg      <= ST_SLIP;
                  sh_cnt_reg     <= '0;
                  sh_inv_cnt_reg <= '0;
                end else if (!hdr_ok && sh_inv_cnt_next == INV_MAX) begin
                  // Loss wins even if this header would also close the window.
                  lock_reg       <= 1'b0;
                  state_reg      <= ST_SLIP;
                  sh_cnt_reg     <= '0;
                  sh_inv_cnt_reg <= '0;
                  if (loss_cnt_reg != 16'hFFFF) begin
                    loss_cnt_reg <= loss_cnt_reg + 16'd1;
                  end
                end else if (sh_cnt_next == CNT_MAX && sh_inv_cnt_next < INV_MAX) begin
                  lock_reg       <= 1'b1;
                  sh_cnt_reg     <= '0;
                  sh_inv_cnt_reg <= '0;
                end else begin
                  sh_cnt_reg     <= sh_cnt_next;
                  sh_inv_cnt_reg <= sh_inv_cnt_next;
                end
              end
            end
            ST_SLIP: begin
              slip_reg     <= 1'b1;
              wait_cnt_reg <= '0;
              state_reg    <= ST_SLIP_WAIT;
            end
            ST_SLIP_WAIT: begin
              if (wait_cnt_reg == WAIT_LAST) begin
                state_reg      <= ST_TEST;
                sh_cnt_reg     <= '0;
                sh_inv_cnt_reg <= '0;
              end else begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
              end
            end
            default: begin
              state_reg <= ST_TEST;
            end
          endcase
        end
      end

      assign o_slip[gi]                  = slip_reg;
      assign o_block_lock[gi]            = lock_reg;
      assign o_lock_loss_count[16*gi +: 16] = loss_cnt_reg;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_all_locked <= 1'b0;
    end else begin
      o_all_locked <= &o_block_lock;
    end
  end

endmodule
